// File: rtl/mult_div_seq_if.sv
// Handshake bundle between the control unit and the mult/div sequencer.
// MULTDIV_ABORT_EN adds the abort line used for exception flush.
interface mult_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULTDIV_ABORT_EN
    logic             abort;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, div_zero, hi, lo
    );
    modport slave (
        input  start, op, a, b, abort,
        output busy, done, div_zero, hi, lo
    );
`else
    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );
    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
`endif
endinterface

// File: rtl/mult_div_seq.sv
// Iterative signed mult (radix-2 Booth) / div (restoring) with HI/LO.
// Optional MULTDIV_ABORT_EN: abort input cancels a running operation.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    mult_div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   pa;
    logic [WIDTH-1:0] pq;
    logic             pq1;
    logic [WIDTH-1:0] mreg;
    logic             opr;
    logic             sa;
    logic             sq;
    logic             done_r;
    logic             dz_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             ld;
    logic             fin;
    logic             dz_n;
    logic             aborting;
    logic [WIDTH:0]   msx;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   trial;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        ld       = 1'b0;
        fin      = 1'b0;
        dz_n     = 1'b0;
        aborting = 1'b0;
`ifdef MULTDIV_ABORT_EN
        aborting = bus.abort && (state != IDLE);
`endif
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op && (bus.b == '0)) begin
                        dz_n = 1'b1;
                    end else begin
                        ld      = 1'b1;
                        state_n = bus.op ? DIV : MULT;
                    end
                end
            end
            MULT, DIV: begin
                if (cnt == '0) state_n = FINISH;
            end
            FINISH: begin
                fin     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (aborting) begin
            state_n = IDLE;
            fin     = 1'b0;
        end
    end

    // Booth step: the extra sign bit in pa keeps -2^(W-1) multiplicands exact
    always_comb begin
        msx = {mreg[WIDTH-1], mreg};
        unique case ({pq[0], pq1})
            2'b01:   msum = pa + msx;
            2'b10:   msum = pa - msx;
            default: msum = pa;
        endcase
    end

    assign rsh   = {pa[WIDTH-1:0], pq[WIDTH-1]};
    assign trial = rsh - {1'b0, mreg};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            pa     <= '0;
            pq     <= '0;
            pq1    <= 1'b0;
            mreg   <= '0;
            opr    <= 1'b0;
            sa     <= 1'b0;
            sq     <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= fin | dz_n;
            dz_r   <= dz_n;
            if (ld) begin
                cnt <= CW'(WIDTH - 1);
                pa  <= '0;
                pq1 <= 1'b0;
                opr <= bus.op;
                sa  <= bus.a[WIDTH-1];
                sq  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                if (bus.op) begin
                    pq   <= mag(bus.a);
                    mreg <= mag(bus.b);
                end else begin
                    pq   <= bus.b;
                    mreg <= bus.a;
                end
            end else if (state == MULT) begin
                pa  <= {msum[WIDTH], msum[WIDTH:1]};
                pq  <= {msum[0], pq[WIDTH-1:1]};
                pq1 <= pq[0];
            end else if (state == DIV) begin
                // restore on negative trial: keep the shifted remainder
                if (trial[WIDTH]) begin
                    pa <= rsh;
                    pq <= {pq[WIDTH-2:0], 1'b0};
                end else begin
                    pa <= trial;
                    pq <= {pq[WIDTH-2:0], 1'b1};
                end
            end
            if (((state == MULT) || (state == DIV)) && (cnt != '0))
                cnt <= cnt - CW'(1);
            if (fin) begin
                if (opr) begin
                    hi_r <= sa ? -pa[WIDTH-1:0] : pa[WIDTH-1:0];
                    lo_r <= sq ? -pq : pq;
                end else begin
                    hi_r <= pa[WIDTH-1:0];
                    lo_r <= pq;
                end
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: vector table, corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_mult_div_seq;
    logic clk;
    logic rst;

    mult_div_seq_if #(.WIDTH(32)) bus();

    mult_div_seq #(.WIDTH(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;
    logic [31:0] ehi = '0;
    logic [31:0] elo = '0;

    typedef struct {
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference: plain signed arithmetic on 64-bit values
    task automatic model(input bit op, input logic [31:0] a,
                         input logic [31:0] b);
        longint la;
        longint lb;
        longint p;
        longint q;
        longint r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (!op) begin
            p   = la * lb;
            ehi = p[63:32];
            elo = p[31:0];
        end else if (b != 0) begin
            q   = la / lb;
            r   = la % lb;
            ehi = r[31:0];
            elo = q[31:0];
        end
    endtask

    // called at a negedge; returns 1ns after the capture edge T
    task automatic start_op(input bit op, input logic [31:0] a,
                            input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(output int n, output int busy_bad);
        n        = 0;
        busy_bad = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done) break;
            if (!bus.busy) busy_bad++;
        end
    endtask

    task automatic check_res(input string name, input int n,
                             input int exp_n, input int busy_bad,
                             input bit exp_dz, input logic [31:0] xh,
                             input logic [31:0] xl);
        chk({name, "_latency"}, 64'(n), 64'(exp_n));
        chk({name, "_busy_span"}, 64'(busy_bad), 64'd0);
        chk({name, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
        chk({name, "_div_zero"}, {63'd0, bus.div_zero}, {63'd0, exp_dz});
        chk({name, "_hilo"}, {bus.hi, bus.lo}, {xh, xl});
    endtask

    vec_t vt[$];

    initial begin
        int n;
        int bb;
        bit op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] sp[5];

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef MULTDIV_ABORT_EN
        bus.abort = 1'b0;
`endif
        vt.push_back('{0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB});
        vt.push_back('{1, 32'hFFFFFFEF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD});
        vt.push_back('{1, 32'd17, 32'hFFFFFFFB, 32'd2, 32'hFFFFFFFD});
        vt.push_back('{0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0});
        vt.push_back('{1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000});
        vt.push_back('{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1});
        vt.push_back('{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1});
        vt.push_back('{1, 32'd100, 32'd7, 32'd2, 32'd14});
        vt.push_back('{1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14});
        vt.push_back('{1, 32'h0ACF1234, 32'h2000, 32'h1234, 32'h5678});

        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_div_zero", {63'd0, bus.div_zero}, 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back: each start is issued on the previous done cycle
        foreach (vt[i]) begin
            start_op(vt[i].op, vt[i].a, vt[i].b);
            wait_done(n, bb);
            check_res($sformatf("vec%0d", i), n, 34, bb, 1'b0,
                      vt[i].hi, vt[i].lo);
        end

        // div by zero with hi/lo holding 0x1234/0x5678
        start_op(1'b1, 32'd55, 32'd0);
        wait_done(n, bb);
        check_res("divzero", n, 1, bb, 1'b1, 32'h1234, 32'h5678);
        @(negedge clk);
        chk("divzero_done_drop", {62'd0, bus.done, bus.div_zero}, 64'd0);
        chk("divzero_idle", {63'd0, bus.busy}, 64'd0);

        // restart mid-operation is ignored
        start_op(1'b0, 32'd7, 32'hFFFFFFFD);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, bb);
        check_res("ignore_start", n, 28, bb, 1'b0,
                  32'hFFFFFFFF, 32'hFFFFFFEB);
        @(negedge clk);

        // asynchronous reset at T+10 aborts with no done
        start_op(1'b0, 32'd1234, 32'd5678);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("async_rst_done", {63'd0, bus.done}, 64'd0);
        chk("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(n, bb);
        chk("no_done_after_rst", {31'd0, bus.done, 32'(n)}, 64'd40);
        ehi = '0;
        elo = '0;

        sp = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1, 32'h0};
        for (int k = 0; k < 40; k++) begin
            op = 1'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)]
                                             : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)]
                                             : $urandom;
            if ($urandom_range(0, 7) == 0) rb = $urandom_range(0, 9);
            model(op, ra, rb);
            start_op(op, ra, rb);
            wait_done(n, bb);
            check_res($sformatf("rnd%0d_op%0d", k, op), n,
                      (op && rb == 0) ? 1 : 34, bb, op && (rb == 0),
                      ehi, elo);
        end

`ifdef MULTDIV_ABORT_EN
        @(negedge clk);
        start_op(1'b0, 32'd3, 32'd9);
        repeat (10) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_busy_pre", {63'd0, bus.busy}, 64'd1);
        @(posedge clk);
        #1 bus.abort = 1'b0;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, {ehi, elo});
        wait_done(n, bb);
        chk("abort_no_done", {31'd0, bus.done, 32'(n)}, 64'd40);
        chk("abort_hilo_kept", {bus.hi, bus.lo}, {ehi, elo});
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
